// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with stall hold, redirect drain and optional halt (FETCH_HALT_DETECT_EN)
module fetch_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirectPC,
   input  logic [15:0] imemData,
   input  logic        imemDone,
   output logic        imemRd,
   output logic [15:0] imemAddr,
   output logic [15:0] outInstruct,
   output logic [15:0] outPlusTwoPC,
   output logic        fetchBusy,
   output logic        halted
);
   localparam logic [15:0] NOP = 16'h0800;
   typedef enum logic [1:0] {RUN, HOLD, DRAIN, HALT} state_t;
   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d, hold_q, hold_d, addr_q, addr_d;
   logic [15:0] pc_plus2, instr, addr;
   logic        rd, busy, halt_data, halt_hold;
   assign pc_plus2     = pc_q + 16'd2;
   assign outPlusTwoPC = pc_plus2;
   assign imemRd       = rd & ~rst;
   assign imemAddr     = addr;
   assign fetchBusy    = busy & ~rst;
   assign outInstruct  = rst ? NOP : instr;
`ifdef FETCH_HALT_DETECT_EN
   assign halt_data = imemData[15:11] == 5'b00000;
   assign halt_hold = hold_q[15:11] == 5'b00000;
   assign halted    = (state_q == HALT) & ~rst;
`else
   assign halt_data = 1'b0;
   assign halt_hold = 1'b0;
   assign halted    = 1'b0;
`endif
   // next state, PC and per-state outputs; redirect outranks stall and imemDone
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      addr_d  = addr_q;
      rd      = 1'b0;
      addr    = pc_q;
      instr   = NOP;
      busy    = 1'b0;
      case (state_q)
         RUN: begin
            rd   = 1'b1;
            busy = ~imemDone;
            if (redirect) begin
               pc_d    = redirectPC;
               addr_d  = pc_q;
               state_d = imemDone ? RUN : DRAIN;
            end else if (imemDone) begin
               instr = imemData;
               if (stall) begin
                  hold_d  = imemData;
                  state_d = HOLD;
               end else if (halt_data) begin
                  state_d = HALT;
               end else begin
                  pc_d = pc_plus2;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = redirectPC;
               hold_d  = NOP;
               state_d = RUN;
            end else begin
               instr = hold_q;
               if (!stall) begin
                  state_d = halt_hold ? HALT : RUN;
                  pc_d    = halt_hold ? pc_q : pc_plus2;
               end
            end
         end
         DRAIN: begin
            rd   = 1'b1;
            addr = addr_q;
            busy = ~imemDone;
            if (redirect) pc_d = redirectPC;
            else if (imemDone) state_d = RUN;
         end
         HALT: begin
            if (redirect) begin
               pc_d    = redirectPC;
               state_d = RUN;
            end
         end
      endcase
   end
   // state registers; reset abandons any outstanding read
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= 16'h0000;
         hold_q  <= NOP;
         addr_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         addr_q  <= addr_d;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_fetch_stage;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imemDone = 1'b0;
   logic [15:0] redirectPC = 16'h0, imemData = 16'h0;
   logic        imemRd, fetchBusy, halted;
   logic [15:0] imemAddr, outInstruct, outPlusTwoPC;
   int          errors = 0, checks = 0;
   typedef struct packed {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] instr;
      logic [15:0] p2;
      logic        busy;
      logic        halt;
   } exp_t;
   exp_t exp_q[$];

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
      .imemData(imemData), .imemDone(imemDone), .imemRd(imemRd), .imemAddr(imemAddr),
      .outInstruct(outInstruct), .outPlusTwoPC(outPlusTwoPC), .fetchBusy(fetchBusy), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int n, input logic [15:0] act, input logic [15:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s vec%0d: got %h expected %h", name, n, act, want);
      end
   endtask

   int vec = 0;
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("imemRd", vec, {15'd0, imemRd}, {15'd0, e.rd});
         chk("imemAddr", vec, imemAddr, e.addr);
         chk("outInstruct", vec, outInstruct, e.instr);
         chk("outPlusTwoPC", vec, outPlusTwoPC, e.p2);
         chk("fetchBusy", vec, {15'd0, fetchBusy}, {15'd0, e.busy});
         chk("halted", vec, {15'd0, halted}, {15'd0, e.halt});
         vec++;
      end
   end

   task automatic cyc(input logic r, s, rdr, input logic [15:0] rpc, d, input logic dn,
                      input logic erd, input logic [15:0] eaddr, einst, ep2, input logic ebusy, ehalt);
      rst = r; stall = s; redirect = rdr; redirectPC = rpc; imemData = d; imemDone = dn;
      exp_q.push_back({erd, eaddr, einst, ep2, ebusy, ehalt});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk);
      #1;
      //   rst stl rdr rpc      data     dn  rd addr     instr    p2       bsy hlt
      cyc(1, 0, 0, 16'h0000, 16'h1111, 1, 0, 16'h0000, 16'h0800, 16'h0002, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h4000, 1, 1, 16'h0000, 16'h4000, 16'h0002, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h4100, 1, 1, 16'h0002, 16'h4100, 16'h0004, 0, 0);
      cyc(0, 0, 1, 16'h0010, 16'h1234, 1, 1, 16'h0004, 16'h0800, 16'h0006, 0, 0);
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0010, 16'h0800, 16'h0012, 1, 0);
      cyc(0, 0, 0, 16'h0000, 16'h5555, 1, 1, 16'h0010, 16'h5555, 16'h0012, 0, 0);
      cyc(0, 0, 1, 16'h0020, 16'h1234, 1, 1, 16'h0012, 16'h0800, 16'h0014, 0, 0);
      cyc(0, 1, 0, 16'h0000, 16'h6666, 1, 1, 16'h0020, 16'h6666, 16'h0022, 0, 0);
      cyc(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0020, 16'h6666, 16'h0022, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0020, 16'h6666, 16'h0022, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0022, 16'h0800, 16'h0024, 1, 0);
      cyc(0, 0, 1, 16'h0030, 16'h0000, 0, 1, 16'h0022, 16'h0800, 16'h0024, 1, 0);
      cyc(0, 0, 0, 16'h0000, 16'h9999, 1, 1, 16'h0022, 16'h0800, 16'h0032, 0, 0);
      cyc(0, 0, 1, 16'h0100, 16'h0000, 0, 1, 16'h0030, 16'h0800, 16'h0032, 1, 0);
      cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0030, 16'h0800, 16'h0102, 1, 0);
      cyc(0, 0, 0, 16'h0000, 16'h7777, 1, 1, 16'h0030, 16'h0800, 16'h0102, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h4200, 1, 1, 16'h0100, 16'h4200, 16'h0102, 0, 0);
      cyc(0, 0, 1, 16'hFFFE, 16'h1234, 1, 1, 16'h0102, 16'h0800, 16'h0104, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h4300, 1, 1, 16'hFFFE, 16'h4300, 16'h0000, 0, 0);
      cyc(0, 1, 0, 16'h0000, 16'h4400, 1, 1, 16'h0000, 16'h4400, 16'h0002, 0, 0);
      cyc(0, 1, 1, 16'h0200, 16'h0000, 0, 0, 16'h0000, 16'h0800, 16'h0002, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0200, 16'h0800, 16'h0202, 1, 0);
      cyc(0, 0, 1, 16'h0040, 16'h0000, 1, 1, 16'h0200, 16'h0800, 16'h0202, 0, 0);
`ifdef FETCH_HALT_DETECT_EN
      cyc(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'h0000, 16'h0042, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h4000, 1, 0, 16'h0040, 16'h0800, 16'h0042, 0, 1);
      cyc(0, 0, 0, 16'h0000, 16'h4000, 1, 0, 16'h0040, 16'h0800, 16'h0042, 0, 1);
      cyc(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 16'h0040, 16'h0800, 16'h0042, 0, 1);
      cyc(0, 0, 0, 16'h0000, 16'h4000, 1, 1, 16'h0000, 16'h4000, 16'h0002, 0, 0);
      cyc(0, 0, 1, 16'h0080, 16'h0000, 1, 1, 16'h0002, 16'h0800, 16'h0004, 0, 0);
`else
      cyc(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'h0000, 16'h0042, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h4500, 1, 1, 16'h0042, 16'h4500, 16'h0044, 0, 0);
      cyc(0, 0, 1, 16'h0080, 16'h0000, 1, 1, 16'h0044, 16'h0800, 16'h0046, 0, 0);
`endif
      cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0080, 16'h0800, 16'h0082, 1, 0);
      cyc(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0080, 16'h0800, 16'h0082, 0, 0);
      cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0800, 16'h0002, 1, 0);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
